// File: rtl/sort_pkg.sv
// Shared types and constants for the hardware bubble-sort sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sort_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD0  = 3'd1,
      ST_RD1  = 3'd2,
      ST_CMP  = 3'd3,
      ST_WR0  = 3'd4,
      ST_WR1  = 3'd5,
      ST_DONE = 3'd6
   } sort_state_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLL = 4'b0111;

   localparam int WORD_BYTES = 8;

endpackage

// File: rtl/sort_index_gen.sv
// Pair index / pass bookkeeping for the bubble sort: j, last, swapped and pair addresses.
// Latency: addresses and flags are combinational from registered state; updates on init/adv.
// Backpressure: none, stepped only by the controlling FSM.
module sort_index_gen
   import sort_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_init,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [LEN_W-1:0]  i_len,
   input  logic              i_adv,
   input  logic              i_swap,
   output logic [ADDR_W-1:0] o_addr_j,
   output logic [ADDR_W-1:0] o_addr_j1,
   output logic              o_pass_end,
   output logic              o_sort_end
);

   logic [ADDR_W-1:0] r_base;
   logic [LEN_W-1:0]  r_j;
   logic [LEN_W-1:0]  r_last;
   logic              r_swapped;
   logic [LEN_W-1:0]  w_j1;
   logic              w_swapped;

   assign w_j1      = r_j + LEN_W'(1);
   assign w_swapped = r_swapped | i_swap;

   assign o_addr_j   = r_base + ADDR_W'(r_j) * ADDR_W'(WORD_BYTES);
   assign o_addr_j1  = r_base + ADDR_W'(w_j1) * ADDR_W'(WORD_BYTES);
   assign o_pass_end = !(w_j1 < r_last);
   // A swap in the current WR1 cycle must count toward this pass.
   assign o_sort_end = !w_swapped || (r_last == LEN_W'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_base    <= '0;
         r_j       <= '0;
         r_last    <= '0;
         r_swapped <= 1'b0;
      end else if (i_init) begin
         r_base    <= i_base;
         r_j       <= '0;
         r_last    <= i_len - LEN_W'(1);
         r_swapped <= 1'b0;
      end else if (i_adv) begin
         if (!o_pass_end) begin
            r_j       <= w_j1;
            r_swapped <= w_swapped;
         end else if (!o_sort_end) begin
            r_last    <= r_last - LEN_W'(1);
            r_j       <= '0;
            r_swapped <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/bubble_sort_ctrl.sv
// In-place ascending bubble sort of 64-bit words in memory, using the shared ALU's Is_Greater flag.
// Latency: 3 cycles per non-swapping pair, 5 per swapping pair; start -> RD0 next cycle.
// Backpressure: none; owns the memory port while busy, start ignored outside IDLE.
module bubble_sort_ctrl
   import sort_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [31:0]       swap_count,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [63:0]       mem_rdata,
   output logic [63:0]       mem_wdata,
   output logic              mem_we,
   output logic [63:0]       alu_a,
   output logic [63:0]       alu_b,
   output logic [3:0]        alu_op,
   input  logic              alu_is_greater
);

   sort_state_t       r_state;
   sort_state_t       w_next;
   logic [63:0]       r_x;
   logic [63:0]       r_y;
   logic [31:0]       r_swap_count;

   logic              w_init;
   logic              w_adv;
   logic              w_swap;
   logic              w_clear;
   logic [ADDR_W-1:0] w_addr_j;
   logic [ADDR_W-1:0] w_addr_j1;
   logic              w_pass_end;
   logic              w_sort_end;

   sort_index_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_idx (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_init     (w_init),
      .i_base     (base_addr),
      .i_len      (len),
      .i_adv      (w_adv),
      .i_swap     (w_swap),
      .o_addr_j   (w_addr_j),
      .o_addr_j1  (w_addr_j1),
      .o_pass_end (w_pass_end),
      .o_sort_end (w_sort_end)
   );

   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_DONE);
   assign swap_count = r_swap_count;
   assign alu_op     = ALU_SUB;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      w_init    = 1'b0;
      w_adv     = 1'b0;
      w_swap    = 1'b0;
      w_clear   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_init  = 1'b1;
               w_clear = 1'b1;
               w_next  = (len >= LEN_W'(2)) ? ST_RD0 : ST_DONE;
            end
         end
         ST_RD0: begin
            mem_addr = w_addr_j;
            w_next   = ST_RD1;
         end
         ST_RD1: begin
            mem_addr = w_addr_j1;
            w_next   = ST_CMP;
         end
         ST_CMP: begin
            // Second operand comes straight off the read port; no extra cycle to register it.
            alu_a = r_x;
            alu_b = mem_rdata;
            if (alu_is_greater) begin
               w_next = ST_WR0;
            end else begin
               w_adv  = 1'b1;
               w_next = (w_pass_end && w_sort_end) ? ST_DONE : ST_RD0;
            end
         end
         ST_WR0: begin
            mem_addr  = w_addr_j;
            mem_wdata = r_y;
            mem_we    = 1'b1;
            w_next    = ST_WR1;
         end
         ST_WR1: begin
            mem_addr  = w_addr_j1;
            mem_wdata = r_x;
            mem_we    = 1'b1;
            w_adv     = 1'b1;
            w_swap    = 1'b1;
            w_next    = (w_pass_end && w_sort_end) ? ST_DONE : ST_RD0;
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x          <= '0;
         r_y          <= '0;
         r_swap_count <= '0;
      end else begin
         if (r_state == ST_RD1) begin
            r_x <= mem_rdata;
         end
         if (r_state == ST_CMP) begin
            r_y <= mem_rdata;
         end
         if (w_clear) begin
            r_swap_count <= '0;
         end else if (w_swap) begin
            r_swap_count <= r_swap_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl with a synchronous-read memory model and comparator ALU.
module tb_bubble_sort_ctrl;
   import sort_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] base_addr;
   logic [15:0] len;
   logic        busy;
   logic        done;
   logic [31:0] swap_count;
   logic [31:0] mem_addr;
   logic [63:0] mem_rdata;
   logic [63:0] mem_wdata;
   logic        mem_we;
   logic [63:0] alu_a;
   logic [63:0] alu_b;
   logic [3:0]  alu_op;
   logic        alu_is_greater;

   logic [63:0] mem [0:127];

   int n_total = 0;
   int n_bad   = 0;
   int n_we    = 0;
   int n_done  = 0;
   int n_busy  = 0;
   int n_acc   = 0;
   int d_we, d_done, d_busy, d_acc, cyc;

   bubble_sort_ctrl #(.ADDR_W(32), .LEN_W(16)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .base_addr      (base_addr),
      .len            (len),
      .busy           (busy),
      .done           (done),
      .swap_count     (swap_count),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .mem_wdata      (mem_wdata),
      .mem_we         (mem_we),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_op         (alu_op),
      .alu_is_greater (alu_is_greater)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign alu_is_greater = (alu_a > alu_b);

   always @(posedge clk) begin
      mem_rdata <= mem[mem_addr[9:3]];
      if (mem_we) mem[mem_addr[9:3]] <= mem_wdata;
   end

   always @(negedge clk) begin
      if (busy && !done) n_busy++;
      if (mem_we)        n_we++;
      if (done)          n_done++;
      if (mem_addr != 0) n_acc++;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
   task automatic run(input logic [31:0] b, input logic [15:0] n, input bit mid_start);
      int b_we, b_done, b_busy, b_acc;
      b_we = n_we; b_done = n_done; b_busy = n_busy; b_acc = n_acc;
      start = 1'b1; base_addr = b; len = n;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 2000) begin
         start = (mid_start && cyc == 4);
         len   = mid_start ? 16'd0 : n;
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0;
      if (!done) chk("done_timeout", 64'(cyc), 64'd0);
      @(posedge clk); #1;
      d_we = n_we - b_we; d_done = n_done - b_done;
      d_busy = n_busy - b_busy; d_acc = n_acc - b_acc;
   endtask

   task automatic load(input int w, input logic [63:0] v);
      mem[w] = v;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 64'd0;
      reset_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_we",    64'(mem_we), 64'd0);
      chk("rst_addr",  64'(mem_addr), 64'd0);
      chk("rst_wdata", mem_wdata, 64'd0);
      chk("rst_alu_a", alu_a, 64'd0);
      chk("rst_alu_b", alu_b, 64'd0);
      chk("rst_swaps", 64'(swap_count), 64'd0);
      chk("rst_aluop", 64'(alu_op), 64'h6);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // mixed [5,3,9,1] at 0x100 -> [1,3,5,9], 4 swaps, 13+8+5 cycles
      load(32, 5); load(33, 3); load(34, 9); load(35, 1);
      run(32'h100, 16'd4, 1'b0);
      chk("mix_m0", mem[32], 64'd1);
      chk("mix_m1", mem[33], 64'd3);
      chk("mix_m2", mem[34], 64'd5);
      chk("mix_m3", mem[35], 64'd9);
      chk("mix_swaps", 64'(swap_count), 64'd4);
      chk("mix_done", 64'(d_done), 64'd1);
      chk("mix_cyc", 64'(cyc), 64'd26);
      chk("mix_we", 64'(d_we), 64'd8);

      // len 0 / len 1: done right after start, no memory traffic, counter cleared
      run(32'h300, 16'd0, 1'b0);
      chk("len0_cyc", 64'(cyc), 64'd0);
      chk("len0_done", 64'(d_done), 64'd1);
      chk("len0_acc", 64'(d_acc), 64'd0);
      chk("len0_swaps", 64'(swap_count), 64'd0);
      run(32'h300, 16'd1, 1'b0);
      chk("len1_cyc", 64'(cyc), 64'd0);
      chk("len1_acc", 64'(d_acc + d_we), 64'd0);

      // already sorted: one pass of 3 pairs, 9 busy cycles, no writes
      load(40, 1); load(41, 2); load(42, 3); load(43, 4);
      run(32'h140, 16'd4, 1'b0);
      chk("srt_cyc", 64'(cyc), 64'd9);
      chk("srt_busy", 64'(d_busy), 64'd9);
      chk("srt_we", 64'(d_we), 64'd0);
      chk("srt_swaps", 64'(swap_count), 64'd0);

      // reverse [8..1]: 28 swaps at 5 cycles each
      for (int i = 0; i < 8; i++) load(48 + i, 64'(8 - i));
      run(32'h180, 16'd8, 1'b0);
      for (int i = 0; i < 8; i++) chk($sformatf("rev_m%0d", i), mem[48 + i], 64'(i + 1));
      chk("rev_swaps", 64'(swap_count), 64'd28);
      chk("rev_cyc", 64'(cyc), 64'd140);

      // unsigned compare: all-ones is the largest
      load(64, 64'hFFFF_FFFF_FFFF_FFFF); load(65, 64'd1);
      run(32'h200, 16'd2, 1'b0);
      chk("uns_m0", mem[64], 64'd1);
      chk("uns_m1", mem[65], 64'hFFFF_FFFF_FFFF_FFFF);
      chk("uns_swaps", 64'(swap_count), 64'd1);

      // equal pair is never written
      load(66, 64'd7); load(67, 64'd7);
      run(32'h210, 16'd2, 1'b0);
      chk("eq_we", 64'(d_we), 64'd0);
      chk("eq_cyc", 64'(cyc), 64'd3);

      // [2,1,3] with a stray start mid-sort: 1 swap, 5+3+3 cycles, single done
      load(72, 2); load(73, 1); load(74, 3);
      run(32'h240, 16'd3, 1'b1);
      chk("mid_m0", mem[72], 64'd1);
      chk("mid_m2", mem[74], 64'd3);
      chk("mid_swaps", 64'(swap_count), 64'd1);
      chk("mid_cyc", 64'(cyc), 64'd11);
      chk("mid_done", 64'(d_done), 64'd1);

      // async reset while in WR0
      load(112, 2); load(113, 1);
      start = 1'b1; base_addr = 32'h380; len = 16'd2;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 0;
      while (!mem_we && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("wr0_reached", 64'(mem_we), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("arst_we", 64'(mem_we), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_state", 64'(dut.r_state == ST_IDLE), 64'd1);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("arst_m0", mem[112], 64'd2);
      chk("arst_m1", mem[113], 64'd1);
      chk("arst_swaps", 64'(swap_count), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/bubble_sort_ctrl.md
# bubble_sort_ctrl

Multi-cycle sequencer that sorts an array of unsigned 64-bit words in data memory, ascending, in place. It borrows the shared 64-bit ALU for every element comparison, using the ALU's Is_Greater flag. It owns one synchronous-read data-memory port while busy. It sits beside the ALU in the single-cycle bubble-sort datapath as a hardware replacement for the software sort loop.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of memory port and base input
- LEN_W, 16, width of element count

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  sort request, sampled in IDLE only
- base_addr  in  ADDR_W  byte address of element 0; must be 8-byte aligned; captured on start
- len  in  LEN_W  element count; captured on start
- busy  out  1  high from the cycle after start until done, inclusive
- done  out  1  one-cycle pulse when the sort completes
- swap_count  out  32  swaps performed by the last or current sort; cleared on start
- mem_addr  out  ADDR_W  byte address
- mem_rdata  in  64  read data, valid one cycle after mem_addr is presented
- mem_wdata  out  64  write data
- mem_we  out  1  write enable, single cycle
- alu_a, alu_b  out  64  ALU operands
- alu_op  out  4  ALU operation code, held at 4'b0110 (SUB)
- alu_is_greater  in  1  ALU flag, unsigned a>b, combinational

## Operation
- States: IDLE, RD0, RD1, CMP, WR0, WR1, DONE.
- **IDLE:** when start=1 and len≥2, latch base_addr and len, clear swap_count, set j=0, last=len-1, swapped=0, and go to RD0. When start=1 and len<2, go to DONE directly with swap_count=0.
- **RD0:** mem_addr=base+8·j.
- **RD1:** mem_addr=base+8·(j+1); capture x=mem_rdata.
- **CMP:** capture y=mem_rdata; alu_a=x, alu_b=y (combinational from rdata this cycle).
  - If alu_is_greater=1, go to WR0.
  - Otherwise, advance.
- **WR0:** mem_addr=base+8·j, mem_wdata=y, mem_we=1.
- **WR1:** mem_addr=base+8·(j+1), mem_wdata=x, mem_we=1; swap_count+=1; swapped=1; advance.
- **Advance:**
  - If j+1<last: j+=1 and go to RD0.
  - Else, end of pass. If swapped=0 or last=1, go to DONE. Otherwise last-=1, j=0, swapped=0, and go to RD0.
- **DONE:** done=1 for one cycle, then IDLE.
- start is ignored in every state except IDLE.
- Equal elements are not swapped, so the sort is stable. Comparison is unsigned, as defined by the ALU flag.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around is not checked.
- mem_we=0 in every state except WR0 and WR1.

## Timing
- Reset values: state IDLE, busy 0, done 0, mem_we 0, mem_addr 0, mem_wdata 0, alu_a 0, alu_b 0, swap_count 0, alu_op 4'b0110.
- Cycle cost: a non-swapping pair takes 3 cycles (RD0, RD1, CMP). A swapping pair takes 5 cycles.
- Start latency: start sampled at edge k puts the block in RD0 during cycle k+1.
- len<2: DONE during cycle k+1, so done is high the cycle after start.
- Asynchronous reset mid-operation:
  - Returns to IDLE immediately and drops mem_we and busy without waiting for a clock edge.
  - A partially completed swap (WR0 done, WR1 not done) leaves memory with a duplicated value. This is accepted.
- swap_count holds its value after DONE until the next accepted start.

## Structure
- Shared package `sort_pkg`:
  - state enum
  - ALU opcode constants: ALU_AND 4'b0000, ALU_OR 4'b0001, ALU_ADD 4'b0010, ALU_SUB 4'b0110, ALU_NOR 4'b1100, ALU_SLL 4'b0111
  - WORD_BYTES=8
- One natural sub-module, `sort_index_gen`: holds j, last and swapped; produces the pair addresses and the end-of-pass and end-of-sort flags. The FSM stays in the top level.

## Test plan
- **Mixed data:** memory [5,3,9,1] at base 0x100, len 4, start → memory [1,3,5,9], swap_count 4, single done pulse.
- **Already sorted:** [1,2,3,4] → exactly 9 busy cycles before DONE, mem_we never asserted, swap_count 0.
- **Short lengths:** len 0 and len 1 → done the cycle after start, no memory access.
- **Reverse order:** [8..1], len 8 → [1..8], swap_count 28.
- **Unsigned ordering:** [0xFFFF_FFFF_FFFF_FFFF, 1] → [1, 0xFFFF_FFFF_FFFF_FFFF]. Equal pair [7,7] → no write.
- **Reset and start-while-busy:** start pulse while busy → ignored, swap_count unchanged. reset_n low during WR0 → mem_we 0 and state IDLE before the next edge, busy 0.
